fetch_controller: RTL and testbench

Sequences instruction fetches from the synchronous-read instruction memory. That memory has a 32-bit byte address, 1-cycle registered read, and no enable. The block owns the fetch PC and drives the memory address. It captures returning words into a 2-entry skid buffer and presents them to decode over a valid/ready handshake. It also handles redirects (branch/jump) and address faults.

---
 rtl/fetch_controller.sv | 79 +++++++
 tb/tb_fetch_controller.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetches into a 2-entry skid buffer with redirect and fault handling
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_Dout,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Instr,
  output logic [31:0] Out_PC,
  output logic        Out_Fault
);
  localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);
  typedef enum logic {RUN, HALT} state_t;
  state_t      state;
  logic [31:0] fetch_pc, tag_pc;
  logic        tag_fault, inflight;
  logic [1:0]  count;
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc [2];
  logic [1:0]  buf_fault;
  logic        pc_fault, pop, issue, idx;
  always_comb begin
    pc_fault = |fetch_pc[1:0] || fetch_pc > LAST;
    pop      = Out_Valid & Out_Ready;
    issue    = state == RUN && !Redirect && ({1'b0, count} + {2'b0, inflight} - {2'b0, pop} < 3'd2);
    idx      = count[1] | (count[0] & ~pop);
    Mem_Addr = pc_fault ? 32'h0 : fetch_pc;
  end
  assign Out_Valid = |count;
  assign Out_Instr = buf_instr[0];
  assign Out_PC    = buf_pc[0];
  assign Out_Fault = buf_fault[0];
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      count     <= 2'd0;
      inflight  <= 1'b0;
      tag_pc    <= 32'h0;
      tag_fault <= 1'b0;
      buf_instr <= '{default: '0};
      buf_pc    <= '{default: '0};
      buf_fault <= 2'b0;
    end else begin
      if (pop) begin
        buf_instr[0] <= buf_instr[1];
        buf_pc[0]    <= buf_pc[1];
        buf_fault[0] <= buf_fault[1];
      end
      if (Redirect) begin
        state    <= RUN;
        fetch_pc <= Redirect_PC;
        count    <= 2'd0;
        inflight <= 1'b0;
      end else begin
        if (inflight) begin
          buf_instr[idx] <= tag_fault ? NOP_INSTR : Mem_Dout;
          buf_pc[idx]    <= tag_pc;
          buf_fault[idx] <= tag_fault;
        end
        count    <= count - {1'b0, pop} + {1'b0, inflight};
        inflight <= issue;
        if (issue) begin
          tag_pc    <= fetch_pc;
          tag_fault <= pc_fault;
          fetch_pc  <= fetch_pc + 32'd4;
          if (pc_fault) state <= HALT;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scoreboard bench for fetch_controller
module tb_fetch_controller;
  logic        Clk, Rst, Redirect, Out_Ready, Out_Valid, Out_Fault;
  logic [31:0] Mem_Addr, Mem_Dout, Redirect_PC, Out_Instr, Out_PC;
  logic [31:0] mem [256];
  int          checks = 0, failures = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;
  exp_t q[$];
  fetch_controller #(.RESET_PC(32'h0), .MEM_BYTES(1024), .NOP_INSTR(32'h13)) dut (
    .Clk(Clk), .Rst(Rst), .Mem_Addr(Mem_Addr), .Mem_Dout(Mem_Dout),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out_Instr(Out_Instr), .Out_PC(Out_PC), .Out_Fault(Out_Fault)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) Mem_Dout <= mem[Mem_Addr[9:2]];
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h0 ? 32'h0011_00b3 : (32'hC0DE_0000 | a);
  endfunction
  function automatic void push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.fault = pc[1:0] != 2'b0 || pc > 32'h3FC;
    e.instr = e.fault ? 32'h13 : word(pc);
    q.push_back(e);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    if (Out_Valid === 1'b1 && Out_Ready) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL xfer_unexpected observed pc=%h expected no transfer", Out_PC);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("xfer_pc", Out_PC, e.pc);
        chk("xfer_instr", Out_Instr, e.instr);
        chk("xfer_fault", 32'(Out_Fault), 32'(e.fault));
      end
    end
    @(posedge Clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word(32'(i * 4));
    Rst = 1'b1; Redirect = 1'b0; Redirect_PC = 32'h0; Out_Ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(Out_Valid), 32'h0);
    chk("rst_instr", Out_Instr, 32'h0);
    chk("rst_pc", Out_PC, 32'h0);
    chk("rst_fault", 32'(Out_Fault), 32'h0);
    chk("rst_addr", Mem_Addr, 32'h0);
    Rst = 1'b0; Out_Ready = 1'b1;
    push(32'h0); push(32'h4); push(32'h8);
    chk("lat_c0", 32'(Out_Valid), 32'h0); tick();
    chk("lat_c1", 32'(Out_Valid), 32'h0); tick();
    for (int i = 0; i < 3; i++) begin
      chk("seq_valid", 32'(Out_Valid), 32'h1);
      tick();
    end
    Out_Ready = 1'b0;
    Rst = 1'b1; tick();
    Rst = 1'b0; push(32'h0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(Out_Valid), 32'h1);
      chk("stall_pc", Out_PC, 32'h0);
      if (i > 0) chk("stall_addr", Mem_Addr, 32'h8);
      tick();
    end
    Out_Ready = 1'b1;
    push(32'h4); push(32'h8); push(32'hC);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(Out_Valid), 32'h1);
      tick();
    end
    Out_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h40;
    tick();
    Redirect = 1'b0; Out_Ready = 1'b1; push(32'h40);
    chk("redir_addr", Mem_Addr, 32'h40);
    chk("redir_r1", 32'(Out_Valid), 32'h0); tick();
    chk("redir_r2", 32'(Out_Valid), 32'h0); tick();
    chk("redir_r3", 32'(Out_Valid), 32'h1); tick();
    Out_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h42;
    tick();
    Redirect = 1'b0; Out_Ready = 1'b1; push(32'h42);
    chk("fault_addr", Mem_Addr, 32'h0);
    tick(); tick();
    chk("fault_valid", 32'(Out_Valid), 32'h1);
    chk("fault_flag", 32'(Out_Fault), 32'h1);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("halt_valid", 32'(Out_Valid), 32'h0);
      chk("halt_addr", Mem_Addr, 32'h0);
      tick();
    end
    Redirect = 1'b1; Redirect_PC = 32'h0;
    tick();
    Redirect = 1'b0; push(32'h0); push(32'h4); push(32'h8);
    tick(); tick();
    chk("resume_valid", 32'(Out_Valid), 32'h1);
    tick(); tick();
    Redirect = 1'b1; Redirect_PC = 32'h3F8;
    chk("redir_xfer_valid", 32'(Out_Valid), 32'h1);
    tick();
    Redirect = 1'b0; push(32'h3F8); push(32'h3FC); push(32'h400);
    chk("flush_r1", 32'(Out_Valid), 32'h0); tick();
    chk("flush_r2", 32'(Out_Valid), 32'h0); tick();
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("end_valid", 32'(Out_Valid), 32'h0);
      chk("end_addr", Mem_Addr, 32'h0);
      tick();
    end
    Out_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h10;
    tick();
    Redirect = 1'b0;
    tick(); tick(); tick(); tick();
    chk("full_valid", 32'(Out_Valid), 32'h1);
    chk("full_pc", Out_PC, 32'h10);
    chk("full_addr", Mem_Addr, 32'h18);
    Rst = 1'b1;
    tick();
    chk("rst2_valid", 32'(Out_Valid), 32'h0);
    chk("rst2_addr", Mem_Addr, 32'h0);
    Rst = 1'b0; Out_Ready = 1'b1; push(32'h0); push(32'h4); push(32'h8);
    tick(); tick(); tick(); tick(); tick();
    Out_Ready = 1'b0;
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
